// File: rtl/tlk2711_tx_cmd_mc.sv
// Multi-channel TX DMA read-command generator: splits per-channel jobs into packet
// commands and grants them round-robin, one outstanding command at a time.
module tlk2711_tx_cmd_mc #(
    parameter int CH_NUM     = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DLEN_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_soft_rst,
    input  logic [CH_NUM-1:0]                i_ch_start,
    input  logic [CH_NUM*ADDR_WIDTH-1:0]     i_ch_base_addr,
    input  logic [CH_NUM*DLEN_WIDTH-1:0]     i_ch_packet_body,
    input  logic [CH_NUM*DLEN_WIDTH-1:0]     i_ch_packet_tail,
    input  logic [CH_NUM*CNT_WIDTH-1:0]      i_ch_body_num,
    output logic                             o_rd_cmd_req,
    input  logic                             i_rd_cmd_ack,
    output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
    input  logic                             i_dma_rd_last,
    output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] o_cur_ch,
    output logic                             o_cur_tail,
    output logic [CH_NUM-1:0]                o_ch_busy,
    output logic [CH_NUM-1:0]                o_ch_done,
    output logic [CH_NUM-1:0]                o_start_err
);

    localparam int CHW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CMDW = DLEN_WIDTH + ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StReq, StData, StNext} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [CMDW-1:0]   cmd_q, cmd_d;
    logic [CHW-1:0]    cur_ch_q, cur_ch_d;
    logic              cur_tail_q, cur_tail_d;
    logic [CHW-1:0]    ptr_q, ptr_d;
    logic [CH_NUM-1:0] busy_q, busy_d;
    logic [CH_NUM-1:0] done_q, done_d;
    logic [CH_NUM-1:0] err_q, err_d;

    logic [ADDR_WIDTH-1:0] addr_q [CH_NUM];
    logic [ADDR_WIDTH-1:0] addr_d [CH_NUM];
    logic [DLEN_WIDTH-1:0] body_q [CH_NUM];
    logic [DLEN_WIDTH-1:0] body_d [CH_NUM];
    logic [DLEN_WIDTH-1:0] tail_q [CH_NUM];
    logic [DLEN_WIDTH-1:0] tail_d [CH_NUM];
    logic [CNT_WIDTH-1:0]  cnt_q  [CH_NUM];
    logic [CNT_WIDTH-1:0]  cnt_d  [CH_NUM];

    logic           sel_found;
    logic [CHW-1:0] sel_ch;
    logic [CHW-1:0] cand;

    // Round-robin search starting one past the last serviced channel.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            cand = CHW'((int'(ptr_q) + 1 + i) % CH_NUM);
            if (!sel_found && busy_q[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cmd_d      = cmd_q;
        cur_ch_d   = cur_ch_q;
        cur_tail_d = cur_tail_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        done_d     = '0;
        err_d      = err_q;
        addr_d     = addr_q;
        body_d     = body_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;

        for (int k = 0; k < CH_NUM; k++) begin
            if (i_ch_start[k]) begin
                if (busy_q[k]) begin
                    err_d[k] = 1'b1;
                end else begin
                    addr_d[k] = i_ch_base_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                    body_d[k] = i_ch_packet_body[k*DLEN_WIDTH +: DLEN_WIDTH];
                    tail_d[k] = i_ch_packet_tail[k*DLEN_WIDTH +: DLEN_WIDTH];
                    cnt_d[k]  = i_ch_body_num[k*CNT_WIDTH +: CNT_WIDTH];
                    // An empty job completes immediately without touching the DMA.
                    if (i_ch_body_num[k*CNT_WIDTH +: CNT_WIDTH] == '0 &&
                        i_ch_packet_tail[k*DLEN_WIDTH +: DLEN_WIDTH] == '0) begin
                        done_d[k] = 1'b1;
                    end else begin
                        busy_d[k] = 1'b1;
                    end
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d  = StReq;
                    req_d    = 1'b1;
                    cur_ch_d = sel_ch;
                    if (cnt_q[sel_ch] != '0) begin
                        cmd_d      = {body_q[sel_ch], addr_q[sel_ch]};
                        cur_tail_d = 1'b0;
                    end else begin
                        cmd_d      = {tail_q[sel_ch], addr_q[sel_ch]};
                        cur_tail_d = 1'b1;
                    end
                end
            end
            StReq: begin
                if (i_rd_cmd_ack) begin
                    req_d   = 1'b0;
                    state_d = StData;
                end
            end
            StData: begin
                if (i_dma_rd_last) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                state_d = StIdle;
                ptr_d   = cur_ch_q;
                if (cur_tail_q) begin
                    busy_d[cur_ch_q] = 1'b0;
                    done_d[cur_ch_q] = 1'b1;
                end else begin
                    cnt_d[cur_ch_q]  = cnt_q[cur_ch_q] - CNT_WIDTH'(1);
                    addr_d[cur_ch_q] = addr_q[cur_ch_q] + ADDR_WIDTH'(body_q[cur_ch_q]);
                    if (cnt_q[cur_ch_q] == CNT_WIDTH'(1) && tail_q[cur_ch_q] == '0) begin
                        busy_d[cur_ch_q] = 1'b0;
                        done_d[cur_ch_q] = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            cur_ch_q   <= '0;
            cur_tail_q <= 1'b0;
            ptr_q      <= CHW'(CH_NUM - 1);
            busy_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else if (i_soft_rst) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            cmd_q      <= '0;
            cur_ch_q   <= '0;
            cur_tail_q <= 1'b0;
            ptr_q      <= CHW'(CH_NUM - 1);
            busy_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cmd_q      <= cmd_d;
            cur_ch_q   <= cur_ch_d;
            cur_tail_q <= cur_tail_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Job parameters only matter while busy, so soft reset need not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH_NUM; k++) begin
                addr_q[k] <= '0;
                body_q[k] <= '0;
                tail_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                addr_q[k] <= addr_d[k];
                body_q[k] <= body_d[k];
                tail_q[k] <= tail_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign o_rd_cmd_req  = req_q;
    assign o_rd_cmd_data = cmd_q;
    assign o_cur_ch      = cur_ch_q;
    assign o_cur_tail    = cur_tail_q;
    assign o_ch_busy     = busy_q;
    assign o_ch_done     = done_q;
    assign o_start_err   = err_q;

endmodule

// File: tb/tb_tlk2711_tx_cmd_mc.sv
// Directed bench for tlk2711_tx_cmd_mc: a simple DMA responder plus per-scenario checks.
module tb_tlk2711_tx_cmd_mc;

    localparam int CH = 4;
    localparam int AW = 48;
    localparam int DW = 16;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             soft_rst = 1'b0;
    logic [CH-1:0]    start = '0;
    logic [CH*AW-1:0] base = '0;
    logic [CH*DW-1:0] body = '0;
    logic [CH*DW-1:0] tail = '0;
    logic [CH*CW-1:0] num = '0;
    logic             req;
    logic             ack = 1'b0;
    logic [DW+AW-1:0] cmd;
    logic             rd_last = 1'b0;
    logic [1:0]       cur_ch;
    logic             cur_tail;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    done;
    logic [CH-1:0]    err;

    int checks = 0;
    int errors = 0;
    int done_cnt [CH];
    int done_order [$];
    int req_rises = 0;
    logic req_prev = 1'b0;

    tlk2711_tx_cmd_mc #(
        .CH_NUM    (CH),
        .ADDR_WIDTH(AW),
        .DLEN_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_soft_rst      (soft_rst),
        .i_ch_start      (start),
        .i_ch_base_addr  (base),
        .i_ch_packet_body(body),
        .i_ch_packet_tail(tail),
        .i_ch_body_num   (num),
        .o_rd_cmd_req    (req),
        .i_rd_cmd_ack    (ack),
        .o_rd_cmd_data   (cmd),
        .i_dma_rd_last   (rd_last),
        .o_cur_ch        (cur_ch),
        .o_cur_tail      (cur_tail),
        .o_ch_busy       (busy),
        .o_ch_done       (done),
        .o_start_err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < CH; k++) done_cnt[k] = 0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < CH; k++) begin
            if (done[k] === 1'b1) begin
                done_cnt[k] = done_cnt[k] + 1;
                done_order.push_back(k);
            end
        end
        if (req === 1'b1 && req_prev !== 1'b1) req_rises = req_rises + 1;
        req_prev = req;
    end

    task automatic set_ch(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] t, input logic [CW-1:0] n);
        base[ch*AW +: AW] = a;
        body[ch*DW +: DW] = b;
        tail[ch*DW +: DW] = t;
        num[ch*CW +: CW]  = n;
    endtask

    // Called on a negedge; returns on the negedge after the capturing posedge.
    task automatic pulse_start(input logic [CH-1:0] m);
        start = m;
        @(negedge clk);
        start = '0;
    endtask

    // DMA responder: ack one cycle after req is seen, rd_last four cycles after ack.
    task automatic serve(output logic [DW+AW-1:0] c, output int ch, output logic tl,
                         output bit ok);
        ok = 1'b0;
        c  = '0;
        ch = 0;
        tl = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            c  = cmd;
            ch = int'(cur_ch);
            tl = cur_tail;
            @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            repeat (3) @(negedge clk);
            rd_last = 1'b1;
            @(negedge clk);
            rd_last = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if (req !== 1'b0 || cmd !== '0 || cur_ch !== 2'd0 || cur_tail !== 1'b0 ||
            busy !== 4'b0 || done !== 4'b0 || err !== 4'b0) begin
            errors++;
            $display("FAIL reset got req=%b cmd=%h ch=%0d tail=%b busy=%b done=%b err=%b want all 0",
                     req, cmd, cur_ch, cur_tail, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_channel();
        logic [DW+AW-1:0] exp_cmd [4];
        logic [DW+AW-1:0] c;
        int ch;
        logic tl;
        bit ok;
        int d0;
        exp_cmd[0] = {16'd512, 48'h1000};
        exp_cmd[1] = {16'd512, 48'h1200};
        exp_cmd[2] = {16'd512, 48'h1400};
        exp_cmd[3] = {16'd100, 48'h1600};
        d0 = done_cnt[0];
        set_ch(0, 48'h1000, 16'd512, 16'd100, 16'd3);
        pulse_start(4'b0001);
        checks++;
        if (busy !== 4'b0001 || req !== 1'b0) begin
            errors++;
            $display("FAIL start_latency1 got busy=%b req=%b want busy=0001 req=0", busy, req);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL start_latency2 got req=%b want 1", req);
        end
        for (int i = 0; i < 4; i++) begin
            serve(c, ch, tl, ok);
            checks++;
            if (!ok || c !== exp_cmd[i] || ch != 0 || tl !== (i == 3)) begin
                errors++;
                $display("FAIL single_cmd%0d got ok=%0d cmd=%h ch=%0d tail=%b want cmd=%h ch=0 tail=%b",
                         i, ok, c, ch, tl, exp_cmd[i], (i == 3));
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt[0] - d0 != 1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done_pulses=%0d busy0=%b want 1 and 0",
                     done_cnt[0] - d0, busy[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [DW+AW-1:0] exp_cmd [4];
        int exp_ch [4];
        logic [DW+AW-1:0] c;
        int ch;
        logic tl;
        bit ok;
        int o0;
        exp_cmd[0] = {16'd128, 48'h2000}; exp_ch[0] = 1;
        exp_cmd[1] = {16'd64,  48'h3000}; exp_ch[1] = 3;
        exp_cmd[2] = {16'd128, 48'h2080}; exp_ch[2] = 1;
        exp_cmd[3] = {16'd64,  48'h3040}; exp_ch[3] = 3;
        o0 = done_order.size();
        set_ch(1, 48'h2000, 16'd128, 16'd0, 16'd2);
        set_ch(3, 48'h3000, 16'd64, 16'd0, 16'd2);
        pulse_start(4'b1010);
        for (int i = 0; i < 4; i++) begin
            serve(c, ch, tl, ok);
            checks++;
            if (!ok || c !== exp_cmd[i] || ch != exp_ch[i] || tl !== 1'b0) begin
                errors++;
                $display("FAIL rr_cmd%0d got ok=%0d cmd=%h ch=%0d tail=%b want cmd=%h ch=%0d tail=0",
                         i, ok, c, ch, tl, exp_cmd[i], exp_ch[i]);
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_order.size() != o0 + 2 || done_order[o0] != 1 || done_order[o0+1] != 3) begin
            errors++;
            $display("FAIL rr_done_order got %0d new pulses want ch1 then ch3",
                     done_order.size() - o0);
        end
    endtask

    task automatic test_degenerate_and_tail_only();
        logic [DW+AW-1:0] c;
        int ch;
        logic tl;
        bit ok;
        int d0;
        int r0;
        d0 = done_cnt[2];
        r0 = req_rises;
        set_ch(2, 48'h4000, 16'd999, 16'd0, 16'd0);
        pulse_start(4'b0100);
        checks++;
        if (done[2] !== 1'b1 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL degenerate_done got done2=%b busy2=%b want 1 and 0", done[2], busy[2]);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (req_rises != r0) begin
            errors++;
            $display("FAIL degenerate_noreq got %0d requests want 0", req_rises - r0);
        end
        set_ch(2, 48'h4000, 16'd999, 16'd64, 16'd0);
        pulse_start(4'b0100);
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd64, 48'h4000} || ch != 2 || tl !== 1'b1) begin
            errors++;
            $display("FAIL tail_only_cmd got ok=%0d cmd=%h ch=%0d tail=%b want cmd=%h ch=2 tail=1",
                     ok, c, ch, tl, {16'd64, 48'h4000});
        end
        repeat (8) @(negedge clk);
        checks++;
        if (req_rises - r0 != 1 || done_cnt[2] - d0 != 2 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL tail_only_end got reqs=%0d dones=%0d busy2=%b want 1, 2, 0",
                     req_rises - r0, done_cnt[2] - d0, busy[2]);
        end
    endtask

    task automatic test_start_error();
        logic [DW+AW-1:0] c;
        int ch;
        logic tl;
        bit ok;
        set_ch(0, 48'h5000, 16'd256, 16'd0, 16'd2);
        pulse_start(4'b0001);
        @(negedge clk);
        set_ch(0, 48'h9000, 16'd8, 16'd8, 16'd5);
        pulse_start(4'b0001);
        checks++;
        if (err !== 4'b0001) begin
            errors++;
            $display("FAIL start_err_set got err=%b want 0001", err);
        end
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd256, 48'h5000} || ch != 0 || tl !== 1'b0) begin
            errors++;
            $display("FAIL start_err_cmd0 got ok=%0d cmd=%h ch=%0d want cmd=%h ch=0",
                     ok, c, ch, {16'd256, 48'h5000});
        end
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd256, 48'h5100} || ch != 0 || tl !== 1'b0) begin
            errors++;
            $display("FAIL start_err_cmd1 got ok=%0d cmd=%h ch=%0d want cmd=%h ch=0",
                     ok, c, ch, {16'd256, 48'h5100});
        end
        repeat (4) @(negedge clk);
        checks++;
        if (err !== 4'b0001 || busy !== 4'b0000 || req !== 1'b0) begin
            errors++;
            $display("FAIL start_err_sticky got err=%b busy=%b req=%b want 0001 0000 0",
                     err, busy, req);
        end
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        checks++;
        if (err !== 4'b0000) begin
            errors++;
            $display("FAIL start_err_clear got err=%b want 0000", err);
        end
    endtask

    task automatic test_resets_mid_job();
        logic [DW+AW-1:0] c;
        int ch;
        logic tl;
        bit ok;
        int n;
        set_ch(1, 48'h6000, 16'd64, 16'd0, 16'd1);
        pulse_start(4'b0010);
        n = 0;
        while (req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        checks++;
        if (req !== 1'b0 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL soft_rst_req got req=%b busy=%b want 0 0000 (req seen=%0d)",
                     req, busy, (n < 20));
        end
        set_ch(1, 48'h7000, 16'd64, 16'd0, 16'd1);
        pulse_start(4'b0010);
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd64, 48'h7000} || ch != 1) begin
            errors++;
            $display("FAIL soft_rst_restart got ok=%0d cmd=%h ch=%0d want cmd=%h ch=1",
                     ok, c, ch, {16'd64, 48'h7000});
        end
        repeat (4) @(negedge clk);

        set_ch(2, 48'h8000, 16'd32, 16'd0, 16'd2);
        pulse_start(4'b0100);
        n = 0;
        while (req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || busy !== 4'b0000 || cur_ch !== 2'd0 || cmd !== '0) begin
            errors++;
            $display("FAIL async_rst got req=%b busy=%b ch=%0d cmd=%h want 0 0000 0 0",
                     req, busy, cur_ch, cmd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(4'b0100);
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd32, 48'h8000} || ch != 2) begin
            errors++;
            $display("FAIL async_rst_restart0 got ok=%0d cmd=%h ch=%0d want cmd=%h ch=2",
                     ok, c, ch, {16'd32, 48'h8000});
        end
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd32, 48'h8020} || ch != 2) begin
            errors++;
            $display("FAIL async_rst_restart1 got ok=%0d cmd=%h ch=%0d want cmd=%h ch=2",
                     ok, c, ch, {16'd32, 48'h8020});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_addr_wrap();
        logic [DW+AW-1:0] c;
        int ch;
        logic tl;
        bit ok;
        int d0;
        d0 = done_cnt[3];
        set_ch(3, 48'hFFFF_FFFF_FF00, 16'd256, 16'd0, 16'd2);
        pulse_start(4'b1000);
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd256, 48'hFFFF_FFFF_FF00} || ch != 3) begin
            errors++;
            $display("FAIL wrap_cmd0 got ok=%0d cmd=%h ch=%0d want cmd=%h ch=3",
                     ok, c, ch, {16'd256, 48'hFFFF_FFFF_FF00});
        end
        serve(c, ch, tl, ok);
        checks++;
        if (!ok || c !== {16'd256, 48'h0000_0000_0000} || ch != 3) begin
            errors++;
            $display("FAIL wrap_cmd1 got ok=%0d cmd=%h ch=%0d want cmd=%h ch=3",
                     ok, c, ch, {16'd256, 48'h0});
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt[3] - d0 != 1 || busy !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_done got dones=%0d busy=%b want 1 0000", done_cnt[3] - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_round_robin();
        test_degenerate_and_tail_only();
        test_start_error();
        test_resets_mid_job();
        test_addr_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
